// File: rtl/jk_pkg.sv
// Shared JK operation encoding ({J,K}) and the single-bit next-state function.
// Used by the JK cell RTL and by the reference model in the bench.
package jk_pkg;

    typedef logic [1:0] jk_op_t;

    localparam jk_op_t JK_HOLD = 2'b00;
    localparam jk_op_t JK_CLR  = 2'b01;
    localparam jk_op_t JK_SET  = 2'b10;
    localparam jk_op_t JK_TGL  = 2'b11;

    // Characteristic equation; X on j/k propagates naturally to the result.
    function automatic logic jk_next(input logic j, input logic k, input logic q);
        return (j & ~q) | (~k & q);
    endfunction

endpackage

// File: rtl/jk_cell.sv
// Single-bit JK register with synchronous active-high reset to a per-bit value.
// Latency 1 clk from j/k/rst sampling to q; no backpressure.
module jk_cell
    import jk_pkg::*;
#(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic j_i,
    input  logic k_i,
    output logic q_o,
    output logic q_bar_o
);

    logic q_q;
    logic q_d;

    always_comb begin
        q_d = jk_next(j_i, k_i, q_q);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q_q <= RESET_VALUE;
        end else begin
            q_q <= q_d;
        end
    end

    // Complement taken from the same register so it can never equal q.
    assign q_o     = q_q;
    assign q_bar_o = ~q_q;

endmodule

// File: rtl/jk_flip_flop.sv
// WIDTH independent JK bits sharing one clock and a synchronous active-high reset.
// Latency 1 clk from J/K/Reset sampling to Q; no backpressure.
module jk_flip_flop
    import jk_pkg::*;
#(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [WIDTH-1:0] J,
    input  logic [WIDTH-1:0] K,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Q_bar
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        jk_cell #(
            .RESET_VALUE (RESET_VALUE[i])
        ) u_cell (
            .clk_i   (CLK),
            .rst_i   (Reset),
            .j_i     (J[i]),
            .k_i     (K[i]),
            .q_o     (Q[i]),
            .q_bar_o (Q_bar[i])
        );
    end

endmodule

// File: tb/tb_jk_flip_flop.sv
// Directed bench: a 1-bit and a 4-bit (reset 1010) instance, checked against hand
// values and a per-edge behavioural model built on the jk_pkg encoding.
module tb_jk_flip_flop;
    import jk_pkg::*;

    logic       clk;
    logic       rst1, rst4;
    logic       j1, k1;
    logic [3:0] j4, k4;
    logic       q1, qb1;
    logic [3:0] q4, qb4;

    logic       m1;
    logic [3:0] m4;

    int nvec = 0;
    int nmis = 0;

    jk_flip_flop #(.WIDTH(1), .RESET_VALUE(1'b0)) dut1 (
        .CLK(clk), .Reset(rst1), .J(j1), .K(k1), .Q(q1), .Q_bar(qb1)
    );

    jk_flip_flop #(.WIDTH(4), .RESET_VALUE(4'b1010)) dut4 (
        .CLK(clk), .Reset(rst4), .J(j4), .K(k4), .Q(q4), .Q_bar(qb4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic model_bit(input jk_op_t op, input logic q);
        logic r;
        case (op)
            JK_HOLD: r = q;
            JK_CLR:  r = 1'b0;
            JK_SET:  r = 1'b1;
            JK_TGL:  r = ~q;
            default: r = 1'bx;
        endcase
        return r;
    endfunction

    always @(posedge clk) begin
        if (rst1) m1 <= 1'b0;
        else      m1 <= model_bit({j1, k1}, m1);
        for (int b = 0; b < 4; b++) begin
            if (rst4) m4[b] <= 1'b0 ^ (b == 1 || b == 3);
            else      m4[b] <= model_bit({j4[b], k4[b]}, m4[b]);
        end
    end

    task automatic cmp(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nmis++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic exp1);
        cmp({tag, "_q1"},     {3'b0, q1},  {3'b0, exp1});
        cmp({tag, "_qb1"},    {3'b0, qb1}, {3'b0, ~exp1});
        cmp({tag, "_q1_mdl"}, {3'b0, q1},  {3'b0, m1});
        cmp({tag, "_q4_mdl"}, q4,  m4);
        cmp({tag, "_qb4_mdl"}, qb4, ~m4);
    endtask

    // Entered 1 ns after an edge: drive at edge+3, sample 1 ns after the next edge.
    task automatic step(input logic j, input logic k, input logic [3:0] jv,
                        input logic [3:0] kv, input logic exp1, input string tag);
        #2;
        j1 = j;  k1 = k;
        j4 = jv; k4 = kv;
        @(posedge clk);
        #1;
        chk_all(tag, exp1);
    endtask

    initial begin
        rst1 = 1'b1; rst4 = 1'b1;
        j1 = 1'b0; k1 = 1'b0;
        j4 = 4'b0; k4 = 4'b0;

        @(posedge clk); #1;                      // 6 ns
        chk_all("rst_e5", 1'b0);
        cmp("rst_q4",  q4,  4'b1010);
        cmp("rst_qb4", qb4, 4'b0101);

        @(posedge clk); #1;                      // 16 ns, reset still held at edge 15
        chk_all("rst_e15", 1'b0);
        rst1 = 1'b0; rst4 = 1'b0;

        step(1'b1, 1'b1, 4'b0011, 4'b0101, 1'b1, "tgl_e25");
        cmp("vec_ops", q4, 4'b1011);
        step(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1, "hold_e35");
        cmp("vec_hold", q4, 4'b1011);
        step(1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0, "tgl_e45");
        step(1'b1, 1'b0, 4'b0000, 4'b0000, 1'b1, "set_e55");
        step(1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, "clr_e65");
        step(1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, "clr_e75");
        step(1'b1, 1'b0, 4'b0000, 4'b0000, 1'b1, "set_e85");

        // Reset wins over a pending toggle on both instances.
        rst1 = 1'b1; rst4 = 1'b1;
        step(1'b1, 1'b1, 4'b1111, 4'b1111, 1'b0, "rstpri_e95");
        cmp("rstpri_q4", q4, 4'b1010);
        rst1 = 1'b0; rst4 = 1'b0;
        step(1'b1, 1'b1, 4'b1111, 4'b1111, 1'b1, "postrst_e105");
        cmp("postrst_q4", q4, 4'b0101);

        // J pulse strictly between edges must not be captured.
        #2;
        j1 = 1'b0; k1 = 1'b0; j4 = 4'b0; k4 = 4'b0;
        #3  j1 = 1'b1;
        #2  j1 = 1'b0;
        @(posedge clk); #1;
        chk_all("glitch_e115", 1'b1);

        step(1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, "clr_pre_tgl");
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b1, 4'b0000, 4'b0000, (i % 2 == 0) ? 1'b1 : 1'b0, "sust_tgl");
        end
        cmp("sust_end", {3'b0, q1}, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/jk_flip_flop.md
Name: jk_flip_flop

Overview:
- Edge-triggered JK flip-flop with a synchronous, active-high reset and complementary outputs.
- General-purpose sequential primitive, used standalone or replicated, for toggle counters, set/clear flags and small state holders.
- Parameterised width: each bit is an independent JK cell sharing one clock and one reset.

Parameters:
- WIDTH, 1, number of independent JK bits. Must be ≥1.
- RESET_VALUE, '0 (all zeros, WIDTH bits), value loaded into Q on reset; Q_bar loads ~RESET_VALUE.

Ports:
- CLK  input  1  system clock; all state changes occur on its rising edge.
- Reset  input  1  synchronous, active-high reset, sampled on the CLK rising edge.
- J  input  WIDTH  per-bit set / toggle request.
- K  input  WIDTH  per-bit clear / toggle request.
- Q  output  WIDTH  registered state.
- Q_bar  output  WIDTH  bitwise complement of Q.

Interface decision (fixed):
- One clock; reset is synchronous and active-high.
- Clock port is CLK; reset port is Reset.

Behaviour:
- All updates occur on the CLK rising edge only. No asynchronous paths from J, K or Reset to Q.
- Reset=1 at an edge: Q <= RESET_VALUE and Q_bar <= ~RESET_VALUE, regardless of J/K. Reset has priority over J/K.
- Reset=0 at an edge, per bit i:
  - J=0, K=0: hold.
  - J=0, K=1: Q[i] <= 0.
  - J=1, K=0: Q[i] <= 1.
  - J=1, K=1: Q[i] <= ~Q[i] (toggle).
- Latency:
  - One clock from J/K/Reset sampling to the Q change.
  - Q is stable between edges; input changes between edges have no effect until the next rising edge.
- Q_bar is always exactly ~Q, including the power-up/pre-reset period.
- Implementation detail: Q_bar is driven combinationally from the Q register, or from a mirrored register kept consistent. It must never be equal to Q.
- Before the first reset edge, Q is X in simulation. Nothing depends on a power-up value; the first Reset edge defines state.
- Bits are fully independent: no cross-bit interaction for any WIDTH.
- Reset deasserted mid-sequence: the first edge with Reset=0 applies the J/K function to RESET_VALUE.
- Reset asserted while toggling: the next edge loads RESET_VALUE, and toggling resumes only after Reset returns to 0.
- X/Z on J or K propagates as X to Q in simulation. No sanitising.

Decomposition:
- Shared package jk_pkg holds a 2-bit JK operation encoding constant set, {J,K}:
  - JK_HOLD = 2'b00
  - JK_CLR = 2'b01
  - JK_SET = 2'b10
  - JK_TGL = 2'b11
- The bench uses these constants for stimulus naming and in its reference model.
- One natural sub-module, jk_cell: a single-bit JK register with Reset and a per-bit reset value.
- Top level generates WIDTH instances of jk_cell and concatenates the Q/Q_bar outputs.
- The bench carries a golden behavioural model, using jk_pkg, that is compared every cycle.

Test Plan:
- Clock period 10 ns, first rising edge at 5 ns.
- Reset and J=K=0: Reset=1 until 15 ns, WIDTH=1 → after edge 5, Q=0, Q_bar=1; Q stays 0 at edge 15.
- Full JK sequence after reset, inputs changed 3 ns after each edge:
  - t=18 J=1,K=1 → edge 25: Q=1.
  - t=28 0,0 → edge 35: Q=1 (hold).
  - t=38 1,1 → edge 45: Q=0.
  - t=48 1,0 → edge 55: Q=1.
  - t=58 0,1 → edge 65: Q=0.
  - t=68 0,1 → edge 75: Q=0.
  - t=78 1,0 → edge 85: Q=1.
  - Q_bar = ~Q at every sample.
- Reset priority: Q=1, J=1,K=1 with Reset=1 at an edge → Q=0, no toggle. Next edge with Reset=0, J=1,K=1 → Q=1.
- Mid-cycle glitch immunity: J pulsed 1 for 2 ns strictly between edges with K=0 → Q unchanged at the next edge.
- Vector mode, WIDTH=4, RESET_VALUE=4'b1010:
  - After reset: Q=1010, Q_bar=0101.
  - Then J=4'b0011, K=4'b0101 → next edge Q=1011. Per-bit ops: bit0 toggle, bit1 set, bit2 clear, bit3 hold.
- Sustained toggle: J=K=1 for 8 consecutive edges from Q=0 → Q alternates 1,0,1,0,… and ends at 0. Q_bar is always the opposite.
